// File: rtl/hilo_ctrl.sv
// HI/LO register controller: launches DIV/MULT units, captures their results
// and handles mthi/mtlo writes. Define HILO_TIMEOUT_EN to enable the watchdog.
module hilo_ctrl #(
   parameter int TIMEOUT_CYC = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_div,
   input  logic        start_mult,
   input  logic        div_stop,
   input  logic        div_zero,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   input  logic        mult_stop,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] wdata,
   input  logic        sel_hi,
   output logic        ctrl_div,
   output logic        ctrl_mult,
   output logic        busy,
   output logic        hilo_done,
   output logic        div_zero_exc,
   output logic        timeout_exc,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] rd_data
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DIV_WAIT  = 2'd1,
      MULT_WAIT = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ctrl_div_q, ctrl_div_d;
   logic             ctrl_mult_q, ctrl_mult_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;
   logic             tmo_q, tmo_d;
   logic             timeout_hit;

   // The watchdog fires on the wait edge where the counter would reach TIMEOUT_CYC.
`ifdef HILO_TIMEOUT_EN
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
   assign timeout_hit = (cnt_q == LAST_CNT);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         ctrl_div_q  <= 1'b0;
         ctrl_mult_q <= 1'b0;
         done_q      <= 1'b0;
         zero_q      <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state       <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         ctrl_div_q  <= ctrl_div_d;
         ctrl_mult_q <= ctrl_mult_d;
         done_q      <= done_d;
         zero_q      <= zero_d;
         tmo_q       <= tmo_d;
      end
   end

   // Unit completions take priority over the watchdog on the same edge.
   always_comb begin
      state_d     = state;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      ctrl_div_d  = 1'b0;
      ctrl_mult_d = 1'b0;
      done_d      = 1'b0;
      zero_d      = 1'b0;
      tmo_d       = 1'b0;
      case (state)
         IDLE: begin
            if (mthi_we) hi_d = wdata;
            if (mtlo_we) lo_d = wdata;
            if (start_div) begin
               state_d    = DIV_WAIT;
               ctrl_div_d = 1'b1;
               cnt_d      = '0;
            end else if (start_mult) begin
               state_d     = MULT_WAIT;
               ctrl_mult_d = 1'b1;
               cnt_d       = '0;
            end
         end
         DIV_WAIT: begin
            if (div_zero) begin
               zero_d  = 1'b1;
               state_d = IDLE;
            end else if (div_stop) begin
               hi_d    = div_hi;
               lo_d    = div_lo;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (timeout_hit) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         MULT_WAIT: begin
            if (mult_stop) begin
               hi_d    = mult_hi;
               lo_d    = mult_lo;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (timeout_hit) begin
               tmo_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign ctrl_div     = ctrl_div_q;
   assign ctrl_mult    = ctrl_mult_q;
   assign hilo_done    = done_q;
   assign div_zero_exc = zero_q;
   assign timeout_exc  = tmo_q;
   assign hi_out       = hi_q;
   assign lo_out       = lo_q;
   assign rd_data      = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized self-checking bench for hilo_ctrl against a transaction-level
// model of the HI/LO registers and the expected per-cycle handshake.
module tb_hilo_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_div, start_mult;
   logic        div_stop, div_zero;
   logic [31:0] div_hi, div_lo;
   logic        mult_stop;
   logic [31:0] mult_hi, mult_lo;
   logic        mthi_we, mtlo_we;
   logic [31:0] wdata;
   logic        sel_hi;
   logic        ctrl_div, ctrl_mult, busy, hilo_done, div_zero_exc, timeout_exc;
   logic [31:0] hi_out, lo_out, rd_data;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mhi, mlo;

   always #5 clk = ~clk;

   hilo_ctrl #(.TIMEOUT_CYC(48)) dut (
      .clk(clk), .reset(reset),
      .start_div(start_div), .start_mult(start_mult),
      .div_stop(div_stop), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
      .mult_stop(mult_stop), .mult_hi(mult_hi), .mult_lo(mult_lo),
      .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata), .sel_hi(sel_hi),
      .ctrl_div(ctrl_div), .ctrl_mult(ctrl_mult), .busy(busy),
      .hilo_done(hilo_done), .div_zero_exc(div_zero_exc), .timeout_exc(timeout_exc),
      .hi_out(hi_out), .lo_out(lo_out), .rd_data(rd_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      start_div  = 1'b0;
      start_mult = 1'b0;
      div_stop   = 1'b0;
      div_zero   = 1'b0;
      mult_stop  = 1'b0;
      mthi_we    = 1'b0;
      mtlo_we    = 1'b0;
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_hi"}, hi_out, mhi);
      checkOutput({tag, "_lo"}, lo_out, mlo);
      checkOutput({tag, "_rd"}, rd_data, sel_hi ? mhi : mlo);
   endtask

   // kind: 0 = div, 1 = mult, 2 = divide-by-zero, 3 = mthi/mtlo (a[0]=HI, a[1]=LO, data=b)
   task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [31:0] b,
                                input int waitCyc, input bit noisy,
                                input bit extraStart, input bit launchWrite);
      logic [63:0] prod;
      logic [31:0] q, r, lw;
      if (kind == 3) begin
         mthi_we = a[0];
         mtlo_we = a[1];
         wdata   = b;
         tick();
         if (a[0]) mhi = b;
         if (a[1]) mlo = b;
         clearInputs();
         checkOutput("mt_busy", 32'(busy), 32'd0);
         checkRegs("mt");
         return;
      end
      if (kind == 1) begin
         start_mult = 1'b1;
      end else begin
         start_div  = 1'b1;
         start_mult = extraStart;
      end
      lw = $urandom;
      if (launchWrite) begin
         mthi_we = 1'b1;
         wdata   = lw;
      end
      tick();
      if (launchWrite) mhi = lw;
      clearInputs();
      checkOutput("launch_ctrl_div", 32'(ctrl_div), 32'(kind != 1));
      checkOutput("launch_ctrl_mult", 32'(ctrl_mult), 32'(kind == 1));
      checkOutput("launch_busy", 32'(busy), 32'd1);
      checkRegs("launch");
      for (int i = 0; i < waitCyc; i++) begin
         if (noisy) begin
            start_div  = 1'($urandom);
            start_mult = 1'($urandom);
            mthi_we    = 1'($urandom);
            mtlo_we    = (i == 0) ? 1'b1 : 1'($urandom);
            wdata      = $urandom;
            sel_hi     = 1'($urandom);
            if (kind == 1) begin
               div_stop = 1'($urandom);
               div_zero = 1'($urandom);
            end else begin
               mult_stop = 1'($urandom);
            end
         end
         tick();
         checkOutput("wait_busy", 32'(busy), 32'd1);
         checkOutput("wait_ctrl", {30'd0, ctrl_div, ctrl_mult}, 32'd0);
         checkOutput("wait_pulses", {29'd0, hilo_done, div_zero_exc, timeout_exc}, 32'd0);
         checkRegs("wait");
      end
      clearInputs();
      case (kind)
         0: begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
            div_hi   = r;
            div_lo   = q;
            div_stop = 1'b1;
         end
         1: begin
            prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            mult_hi   = prod[63:32];
            mult_lo   = prod[31:0];
            mult_stop = 1'b1;
            div_zero  = noisy;
         end
         default: begin
            div_hi   = $urandom;
            div_lo   = $urandom;
            div_zero = 1'b1;
            div_stop = 1'($urandom);
         end
      endcase
      tick();
      clearInputs();
      if (kind == 0) begin
         mhi = r;
         mlo = q;
      end else if (kind == 1) begin
         mhi = prod[63:32];
         mlo = prod[31:0];
      end
      checkOutput("end_done", 32'(hilo_done), 32'(kind != 2));
      checkOutput("end_zero_exc", 32'(div_zero_exc), 32'(kind == 2));
      checkOutput("end_busy", 32'(busy), 32'd0);
      checkRegs("end");
      tick();
      checkOutput("post_pulses", {29'd0, hilo_done, div_zero_exc, timeout_exc}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          kind;
      reset   = 1'b1;
      sel_hi  = 1'b0;
      wdata   = '0;
      div_hi  = '0;
      div_lo  = '0;
      mult_hi = '0;
      mult_lo = '0;
      clearInputs();
      mhi = '0;
      mlo = '0;
      repeat (3) tick();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_outs", {26'd0, ctrl_div, ctrl_mult, hilo_done, div_zero_exc, timeout_exc, 1'b0}, 32'd0);
      checkRegs("rst");
      reset = 1'b0;

      // Directed cases: 100/7, -100/7, mthi read-back, preloaded divide-by-zero
      applyStimulus(0, 32'd100, 32'd7, 3, 1'b0, 1'b0, 1'b0);
      checkOutput("d100_hi", hi_out, 32'd2);
      checkOutput("d100_lo", lo_out, 32'd14);
      applyStimulus(0, -32'sd100, 32'd7, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("dm100_hi", hi_out, 32'hFFFFFFFE);
      checkOutput("dm100_lo", lo_out, 32'hFFFFFFF2);
      sel_hi = 1'b1;
      applyStimulus(3, 32'd1, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
      checkOutput("mthi_rd", rd_data, 32'hDEADBEEF);
      applyStimulus(0, 32'd55, 32'd4, 4, 1'b1, 1'b0, 1'b0);
      applyStimulus(3, 32'd3, 32'h5, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2, 32'd9, 32'd0, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("dz_hi", hi_out, 32'h5);
      checkOutput("dz_lo", lo_out, 32'h5);
      applyStimulus(0, 32'd1000, 32'd3, 1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1, 32'hFFFFFFFF, 32'd12345, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 3, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a divide aborts it without any later update
      applyStimulus(3, 32'd3, 32'h0BADF00D, 0, 1'b0, 1'b0, 1'b0);
      start_div = 1'b1;
      tick();
      clearInputs();
      repeat (10) tick();
      #2;
      reset = 1'b1;
      #1;
      mhi = '0;
      mlo = '0;
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkRegs("arst");
      tick();
      reset    = 1'b0;
      div_hi   = 32'h11111111;
      div_lo   = 32'h22222222;
      div_stop = 1'b1;
      tick();
      clearInputs();
      checkOutput("arst_no_done", 32'(hilo_done), 32'd0);
      checkRegs("arst_after");
      applyStimulus(1, 32'd6, 32'd7, 1, 1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 3));
         ra   = $urandom;
         if (ra == 32'h80000000) ra = 32'd1;
         rb   = (kind == 1 || kind == 3) ? $urandom : 32'($urandom_range(1, 5000));
         if (kind == 0 && $urandom_range(0, 1) == 1) rb = -rb;
         applyStimulus(kind, ra, rb, int'($urandom_range(0, 6)), 1'($urandom),
                       1'($urandom), 1'($urandom));
      end

      // Watchdog behaviour on a multiply whose unit never answers
      start_mult = 1'b1;
      tick();
      clearInputs();
`ifdef HILO_TIMEOUT_EN
      for (int i = 1; i < 48; i++) begin
         tick();
         checkOutput("tmo_early", {30'd0, busy, timeout_exc}, 32'd2);
      end
      tick();
      checkOutput("tmo_fire", 32'(timeout_exc), 32'd1);
      checkOutput("tmo_busy", 32'(busy), 32'd0);
      checkRegs("tmo");
      tick();
      checkOutput("tmo_pulse_end", 32'(timeout_exc), 32'd0);
`else
      for (int i = 0; i < 60; i++) begin
         tick();
         checkOutput("hold_wait", {30'd0, busy, timeout_exc}, 32'd2);
      end
      mult_hi   = 32'hA5A5A5A5;
      mult_lo   = 32'h5A5A5A5A;
      mult_stop = 1'b1;
      tick();
      clearInputs();
      mhi = 32'hA5A5A5A5;
      mlo = 32'h5A5A5A5A;
      checkOutput("hold_done", 32'(hilo_done), 32'd1);
      checkRegs("hold");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 48, maximum wait cycles for a unit result before abort.
REQ-002 SHALL have ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_div  in  1  control-unit request to run DIV
- start_mult  in  1  control-unit request to run MULT
- div_stop  in  1  divider done pulse
- div_zero  in  1  divider divide-by-zero flag
- div_hi  in  32  divider remainder
- div_lo  in  32  divider quotient
- mult_stop  in  1  multiplier done pulse
- mult_hi  in  32  product high word
- mult_lo  in  32  product low word
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  32  mthi/mtlo data
- sel_hi  in  1  read select (1=HI, 0=LO)
- ctrl_div  out  1  one-cycle launch pulse to divider
- ctrl_mult  out  1  one-cycle launch pulse to multiplier
- busy  out  1  operation in flight
- hilo_done  out  1  one-cycle pulse: HI/LO updated from a unit
- div_zero_exc  out  1  one-cycle divide-by-zero exception pulse
- timeout_exc  out  1  one-cycle watchdog pulse
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- rd_data  out  32  selected HI or LO

Function
REQ-003 SHALL implement FSM states IDLE, DIV_WAIT, MULT_WAIT.
REQ-004 IDLE: start_div sampled high at edge N SHALL drive ctrl_div high for exactly the cycle after N and enter DIV_WAIT; start_mult likewise with ctrl_mult and MULT_WAIT.
REQ-005 start_div and start_mult both high in IDLE: div SHALL win; mult request dropped.
REQ-006 start_div/start_mult while busy SHALL be ignored.
REQ-007 DIV_WAIT: div_zero sampled high SHALL pulse div_zero_exc for one cycle, leave HI/LO unchanged, return to IDLE.
REQ-008 DIV_WAIT: div_stop high with div_zero low SHALL load HI<=div_hi, LO<=div_lo at that edge, pulse hilo_done the next cycle, return to IDLE.
REQ-009 MULT_WAIT: mult_stop high SHALL load HI<=mult_hi, LO<=mult_lo, pulse hilo_done, return to IDLE; div_* inputs ignored in MULT_WAIT.
REQ-010 Unit outputs SHALL pass unmodified (no sign correction).
REQ-011 busy SHALL be high exactly when state != IDLE, decoded from the state register.
REQ-012 mthi_we/mtlo_we SHALL write only in IDLE; writes while busy dropped; both high writes both registers.
REQ-013 mthi/mtlo write and start_* in the same IDLE cycle: write SHALL commit, operation launches.
REQ-014 rd_data SHALL be combinational: sel_hi ? HI : LO, reflecting registered values.
REQ-015 Wait-cycle counter SHALL clear on entering a WAIT state and increment each WAIT cycle.

Reset
REQ-016 reset high SHALL asynchronously force IDLE, HI=LO=0, counter=0, all pulse outputs and busy low.
REQ-017 reset during a WAIT state SHALL abort with no HI/LO update and no exception pulse.
REQ-018 After reset deassertion, first start_* SHALL be accepted on the next edge.

Configuration
REQ-019 Macro HILO_TIMEOUT_EN defined: counter reaching TIMEOUT_CYC in a WAIT state SHALL pulse timeout_exc one cycle, leave HI/LO unchanged, return to IDLE; a done/zero input on that same edge wins over timeout.
REQ-020 HILO_TIMEOUT_EN undefined: no watchdog; timeout_exc tied 0; WAIT states held until done/zero or reset.

Verification
REQ-021 start_div, divider a=100 b=7 -> ctrl_div 1 cycle, busy until div_stop, HI=2, LO=14, hilo_done 1 cycle.
REQ-022 a=-100 b=7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE unchanged from divider.
REQ-023 HI=LO=0x5 preloaded, a=9 b=0 -> div_zero_exc 1 cycle, HI=LO=0x5, busy low after.
REQ-024 mthi_we wdata=0xDEADBEEF in IDLE, sel_hi=1 -> rd_data=0xDEADBEEF next cycle; mtlo_we during DIV_WAIT -> LO unchanged.
REQ-025 reset asserted 10 cycles into DIV_WAIT -> immediate IDLE, HI=LO=0, no hilo_done on later div_stop.
REQ-026 HILO_TIMEOUT_EN, start_mult, mult_stop never asserted -> timeout_exc at wait cycle 48, busy low, HI/LO unchanged.
